bus_arbiter: RTL and testbench

- Sequences and shares the single data-memory / IO bus between two requesters: port 0 = CPU data path (ld/st/ior/iow), port 1 = debug/loader.
- Serialises one transaction at a time.
- Drives the fixed-latency memory and the handshaked IO peripheral bus.
- Returns one-cycle completion pulses with read data or a timeout error.

---
 rtl/mycpu_pkg.sv | 33 +++
 rtl/bus_arbiter_rr_arb2.sv | 24 ++
 rtl/bus_arbiter.sv | 161 ++++++++++++++++
 tb/tb_bus_arbiter.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mycpu_pkg.sv
// Shared types and constants for the CPU data-bus arbiter.
package mycpu_pkg;

    // Default bus geometry; bus_arbiter parameters default to these values
    localparam int BUS_AW = 16;
    localparam int BUS_DW = 16;

    // Requester port indices
    localparam logic PORT_CPU = 1'b0;
    localparam logic PORT_DBG = 1'b1;

    // Arbiter sequencing states
    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_MEM,
        ARB_IO,
        ARB_RESP
    } arb_state_t;

    // Command captured from the granted port at grant time
    typedef struct packed {
        logic              we;
        logic              iom;
        logic [BUS_AW-1:0] addr;
        logic [BUS_DW-1:0] wdata;
    } bus_cmd_t;

    // Larger of two non-negative integers, used to size shared counters
    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/bus_arbiter_rr_arb2.sv
// Two-way round-robin picker. Purely combinational; the caller owns the
// last-grant register and updates it when a grant is taken.
module rr_arb2
    import mycpu_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last_gnt,
    output logic       gnt_valid,
    output logic       gnt_idx
);

    // Single requester wins outright; on a tie the port that did not win last time goes
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        gnt_valid = |req;
        gnt_idx   = PORT_CPU;
        if (req == 2'b11) begin
            gnt_idx = ~last_gnt;
        end else if (req[PORT_DBG]) begin
            gnt_idx = PORT_DBG;
        end
    end

endmodule

// File: rtl/bus_arbiter.sv
// Serialises data-memory and IO bus transactions from the CPU data path
// (port 0) and the debug/loader (port 1). One transaction at a time:
// IDLE -> MEM or IO -> RESP -> IDLE, with a one-cycle done pulse per access.
module bus_arbiter
    import mycpu_pkg::*;
#(
    parameter int AW         = BUS_AW,
    parameter int DW         = BUS_DW,
    parameter int MEM_LAT    = 1,
    parameter int IO_TIMEOUT = 15
) (
    input  logic            clk,
    input  logic            rst,

    // Requester side
    input  logic [1:0]      req,
    input  logic [1:0]      we,
    input  logic [1:0]      iom,
    input  logic [2*AW-1:0] addr,
    input  logic [2*DW-1:0] wdata,
    output logic [1:0]      done,
    output logic [DW-1:0]   rdata,
    output logic            err,
    output logic            busy,

    // Fixed-latency memory
    output logic            mem_en,
    output logic            mem_we,
    output logic [AW-1:0]   mem_addr,
    output logic [DW-1:0]   mem_wdata,
    input  logic [DW-1:0]   mem_rdata,

    // Handshaked IO bus
    output logic            io_req,
    output logic            io_we,
    output logic [AW-1:0]   io_addr,
    output logic [DW-1:0]   io_wdata,
    input  logic [DW-1:0]   io_rdata,
    input  logic            io_ack
);

    // One counter serves both the memory latency and the IO timeout
    localparam int CNT_MAX = max_int(MEM_LAT, IO_TIMEOUT);
    localparam int CW      = $clog2(CNT_MAX + 1);

    localparam logic [CW-1:0] MEM_LAST = CW'(MEM_LAT);
    localparam logic [CW-1:0] IO_LAST  = CW'(IO_TIMEOUT - 1);

    arb_state_t    state;
    bus_cmd_t      cmd;
    bus_cmd_t      grant_cmd;
    logic          idx;
    logic          last_gnt;
    logic [CW-1:0] cnt;
    logic          gnt_valid;
    logic          gnt_idx;

    logic          in_mem;
    logic          in_io;
    logic          io_timeout_hit;

    rr_arb2 u_rr_arb2 (
        .req       (req),
        .last_gnt  (last_gnt),
        .gnt_valid (gnt_valid),
        .gnt_idx   (gnt_idx)
    );

    // Select the granted port's command fields from the flat request buses
    always_comb begin
        grant_cmd       = '0;
        grant_cmd.we    = gnt_idx ? we[1]  : we[0];
        grant_cmd.iom   = gnt_idx ? iom[1] : iom[0];
        grant_cmd.addr  = gnt_idx ? addr[2*AW-1:AW]  : addr[AW-1:0];
        grant_cmd.wdata = gnt_idx ? wdata[2*DW-1:DW] : wdata[DW-1:0];
    end

    // Bus phase decode, qualified by the latched space select
    assign in_mem = (state == ARB_MEM) && !cmd.iom;
    assign in_io  = (state == ARB_IO)  &&  cmd.iom;

    // Timeout fires at the end of the IO_TIMEOUT-th IO cycle; 0 disables it
    assign io_timeout_hit = (IO_TIMEOUT != 0) && (cnt == IO_LAST);

    // Bus outputs decoded from registered state only; req never reaches them
    always_comb begin
        busy      = (state != ARB_IDLE);
        mem_en    = in_mem && (cnt == '0);
        mem_we    = mem_en && cmd.we;
        mem_addr  = in_mem ? cmd.addr  : '0;
        mem_wdata = in_mem ? cmd.wdata : '0;
        io_req    = in_io;
        io_we     = in_io && cmd.we;
        io_addr   = in_io ? cmd.addr  : '0;
        io_wdata  = in_io ? cmd.wdata : '0;
    end

    // Transaction FSM: grant, run the bus phase, pulse done for one cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ARB_IDLE;
            cmd      <= '0;
            idx      <= PORT_CPU;
            last_gnt <= PORT_DBG;
            cnt      <= '0;
            done     <= '0;
            rdata    <= '0;
            err      <= 1'b0;
        end else begin
            // NOTE: state is updated with non-blocking assignments so every register sees pre-edge values.
            done  <= '0;
            rdata <= '0;
            err   <= 1'b0;

            case (state)
                ARB_IDLE: begin
                    if (gnt_valid) begin
                        idx      <= gnt_idx;
                        last_gnt <= gnt_idx;
                        cmd      <= grant_cmd;
                        cnt      <= '0;
                        state    <= grant_cmd.iom ? ARB_IO : ARB_MEM;
                    end
                end

                ARB_MEM: begin
                    if (cnt == MEM_LAST) begin
                        done[idx] <= 1'b1;
                        rdata     <= cmd.we ? '0 : mem_rdata;
                        state     <= ARB_RESP;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end

                ARB_IO: begin
                    if (io_ack) begin
                        done[idx] <= 1'b1;
                        rdata     <= cmd.we ? '0 : io_rdata;
                        state     <= ARB_RESP;
                    end else if (io_timeout_hit) begin
                        done[idx] <= 1'b1;
                        err       <= 1'b1;
                        state     <= ARB_RESP;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end

                ARB_RESP: begin
                    state <= ARB_IDLE;
                end

                default: begin
                    state <= ARB_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed self-checking bench for bus_arbiter. Inputs change and outputs
// are sampled 1 time unit after each rising edge; "cycle n" is the clock
// period following the n-th edge after the request is presented.
module tb_bus_arbiter;

    localparam int AW = 16;
    localparam int DW = 16;

    logic            clk = 1'b0;
    logic            rst = 1'b1;

    // Main instance, MEM_LAT = 1
    logic [1:0]      req   = '0;
    logic [1:0]      we    = '0;
    logic [1:0]      iom   = '0;
    logic [2*AW-1:0] addr  = '0;
    logic [2*DW-1:0] wdata = '0;
    logic [1:0]      done;
    logic [DW-1:0]   rdata;
    logic            err;
    logic            busy;
    logic            mem_en;
    logic            mem_we;
    logic [AW-1:0]   mem_addr;
    logic [DW-1:0]   mem_wdata;
    logic [DW-1:0]   mem_rdata = '0;
    logic            io_req;
    logic            io_we;
    logic [AW-1:0]   io_addr;
    logic [DW-1:0]   io_wdata;
    logic [DW-1:0]   io_rdata = '0;
    logic            io_ack = 1'b0;

    // Second instance, MEM_LAT = 3
    logic [1:0]      req3   = '0;
    logic [1:0]      we3    = '0;
    logic [2*AW-1:0] addr3  = '0;
    logic [2*DW-1:0] wdata3 = '0;
    logic [1:0]      done3;
    logic [DW-1:0]   rdata3;
    logic            err3;
    logic            busy3;
    logic            mem_en3;
    logic            mem_we3;
    logic [AW-1:0]   mem_addr3;
    logic [DW-1:0]   mem_wdata3;
    logic            io_req3;
    logic            io_we3;
    logic [AW-1:0]   io_addr3;
    logic [DW-1:0]   io_wdata3;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    bus_arbiter #(.AW(AW), .DW(DW), .MEM_LAT(1), .IO_TIMEOUT(15)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .we        (we),
        .iom       (iom),
        .addr      (addr),
        .wdata     (wdata),
        .done      (done),
        .rdata     (rdata),
        .err       (err),
        .busy      (busy),
        .mem_en    (mem_en),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .io_req    (io_req),
        .io_we     (io_we),
        .io_addr   (io_addr),
        .io_wdata  (io_wdata),
        .io_rdata  (io_rdata),
        .io_ack    (io_ack)
    );

    bus_arbiter #(.AW(AW), .DW(DW), .MEM_LAT(3), .IO_TIMEOUT(15)) dut3 (
        .clk       (clk),
        .rst       (rst),
        .req       (req3),
        .we        (we3),
        .iom       (2'b00),
        .addr      (addr3),
        .wdata     (wdata3),
        .done      (done3),
        .rdata     (rdata3),
        .err       (err3),
        .busy      (busy3),
        .mem_en    (mem_en3),
        .mem_we    (mem_we3),
        .mem_addr  (mem_addr3),
        .mem_wdata (mem_wdata3),
        .mem_rdata (mem_rdata),
        .io_req    (io_req3),
        .io_we     (io_we3),
        .io_addr   (io_addr3),
        .io_wdata  (io_wdata3),
        .io_rdata  (io_rdata),
        .io_ack    (1'b0)
    );

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Hard stop in case something upstream wedges the run
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int io_cnt;
        int done_cyc;
        logic [1:0] done_seen;
        logic err_seen;
        logic [DW-1:0] rdata_seen;
        int en_cnt;

        // ---------------- reset state ----------------
        cyc();
        cyc();
        check("rst_done",   32'(done),    32'h0);
        check("rst_rdata",  32'(rdata),   32'h0);
        check("rst_err",    32'(err),     32'h0);
        check("rst_busy",   32'(busy),    32'h0);
        check("rst_mem_en", 32'(mem_en),  32'h0);
        check("rst_io_req", 32'(io_req),  32'h0);
        rst = 1'b0;

        // ---------------- CPU memory read, MEM_LAT=1 ----------------
        req = 2'b01; we = 2'b00; iom = 2'b00;
        addr = {16'h0000, 16'h0010};
        cyc();  // cycle 1
        check("rd_c1_mem_en",   32'(mem_en),   32'h1);
        check("rd_c1_mem_addr", 32'(mem_addr), 32'h0010);
        check("rd_c1_mem_we",   32'(mem_we),   32'h0);
        check("rd_c1_busy",     32'(busy),     32'h1);
        cyc();  // cycle 2
        check("rd_c2_mem_en",   32'(mem_en),   32'h0);
        check("rd_c2_done",     32'(done),     32'h0);
        mem_rdata = 16'h1234;
        cyc();  // cycle 3
        check("rd_c3_done",  32'(done),  32'h1);
        check("rd_c3_rdata", 32'(rdata), 32'h1234);
        check("rd_c3_err",   32'(err),   32'h0);
        req = 2'b00;
        cyc();  // cycle 4
        check("rd_c4_done",  32'(done),  32'h0);
        check("rd_c4_rdata", 32'(rdata), 32'h0);
        check("rd_c4_busy",  32'(busy),  32'h0);

        // ---------------- both ports, continuous memory traffic ----------------
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        mem_rdata = 16'h5A5A;
        req = 2'b11; we = 2'b00; iom = 2'b00;
        addr = {16'h0200, 16'h0100};
        for (int c = 1; c <= 15; c++) begin
            logic [1:0] exp_done;
            cyc();
            exp_done = (c % 4 == 3) ? (((c / 4) % 2 == 0) ? 2'b01 : 2'b10) : 2'b00;
            check($sformatf("rr_c%0d_done", c), 32'(done), 32'(exp_done));
            if (c % 4 == 1) begin
                check($sformatf("rr_c%0d_mem_en", c), 32'(mem_en), 32'h1);
                check($sformatf("rr_c%0d_mem_addr", c), 32'(mem_addr),
                      ((c / 4) % 2 == 0) ? 32'h0100 : 32'h0200);
            end
            if (exp_done != 2'b00) begin
                check($sformatf("rr_c%0d_rdata", c), 32'(rdata), 32'h5A5A);
            end
        end
        req = 2'b00;
        cyc();
        check("rr_end_busy", 32'(busy), 32'h0);

        // ---------------- DBG IO write, ack in 4th IO cycle ----------------
        io_rdata = 16'hCAFE;
        req = 2'b10; we = 2'b10; iom = 2'b10;
        addr  = {16'h0003, 16'h0000};
        wdata = {16'h00FF, 16'h0000};
        for (int c = 1; c <= 4; c++) begin
            cyc();
            check($sformatf("iow_c%0d_io_req", c),   32'(io_req),   32'h1);
            check($sformatf("iow_c%0d_io_we", c),    32'(io_we),    32'h1);
            check($sformatf("iow_c%0d_io_addr", c),  32'(io_addr),  32'h0003);
            check($sformatf("iow_c%0d_io_wdata", c), 32'(io_wdata), 32'h00FF);
            check($sformatf("iow_c%0d_done", c),     32'(done),     32'h0);
        end
        io_ack = 1'b1;
        cyc();  // cycle 5
        check("iow_done",   32'(done),   32'h2);
        check("iow_err",    32'(err),    32'h0);
        check("iow_rdata",  32'(rdata),  32'h0);
        check("iow_io_req", 32'(io_req), 32'h0);
        io_ack = 1'b0;
        req = 2'b00;
        cyc();
        check("iow_end_busy", 32'(busy), 32'h0);

        // ---------------- CPU IO read, timeout ----------------
        io_rdata = 16'hDEAD;
        req = 2'b01; we = 2'b00; iom = 2'b01;
        addr  = {16'h0000, 16'h0044};
        wdata = '0;
        io_cnt = 0; done_cyc = 0;
        done_seen = '0; err_seen = 1'b0; rdata_seen = '0;
        for (int c = 1; c <= 30; c++) begin
            cyc();
            if (io_req) io_cnt++;
            if (done != 2'b00) begin
                done_cyc   = c;
                done_seen  = done;
                err_seen   = err;
                rdata_seen = rdata;
                break;
            end
        end
        check("tmo_io_req_cycles", 32'(io_cnt),     32'd15);
        check("tmo_done_cycle",    32'(done_cyc),   32'd16);
        check("tmo_done",          32'(done_seen),  32'h1);
        check("tmo_err",           32'(err_seen),   32'h1);
        check("tmo_rdata",         32'(rdata_seen), 32'h0);
        req = 2'b00;
        cyc();
        check("tmo_end_busy",   32'(busy),   32'h0);
        check("tmo_end_io_req", 32'(io_req), 32'h0);
        check("tmo_end_err",    32'(err),    32'h0);

        // ---------------- reset during IO ----------------
        req = 2'b01; we = 2'b00; iom = 2'b01;
        addr = {16'h0222, 16'h0111};
        cyc();  // cycle 1
        check("rio_c1_io_req", 32'(io_req), 32'h1);
        cyc();  // cycle 2
        check("rio_c2_io_req", 32'(io_req), 32'h1);
        rst = 1'b1;
        cyc();  // cycle 3
        check("rio_c3_io_req", 32'(io_req), 32'h0);
        check("rio_c3_busy",   32'(busy),   32'h0);
        check("rio_c3_done",   32'(done),   32'h0);
        rst = 1'b0;
        req = 2'b11; iom = 2'b00;
        cyc();  // cycle 4
        check("rio_c4_mem_en",   32'(mem_en),   32'h1);
        check("rio_c4_mem_addr", 32'(mem_addr), 32'h0111);
        check("rio_c4_done",     32'(done),     32'h0);
        cyc();  // cycle 5
        check("rio_c5_done", 32'(done), 32'h0);
        cyc();  // cycle 6
        check("rio_c6_done", 32'(done), 32'h1);
        req = 2'b00;
        cyc();
        check("rio_end_busy", 32'(busy), 32'h0);

        // ---------------- MEM_LAT=3, CPU memory write ----------------
        mem_rdata = 16'h7777;
        req3 = 2'b01; we3 = 2'b01;
        addr3  = {16'h0000, 16'h00A0};
        wdata3 = {16'h0000, 16'hBEEF};
        en_cnt = 0; done_cyc = 0; done_seen = '0; rdata_seen = '1;
        for (int c = 1; c <= 12; c++) begin
            cyc();
            if (mem_en3) begin
                en_cnt++;
                check("lat3_mem_we",    32'(mem_we3),    32'h1);
                check("lat3_mem_addr",  32'(mem_addr3),  32'h00A0);
                check("lat3_mem_wdata", 32'(mem_wdata3), 32'hBEEF);
            end
            if (done3 != 2'b00) begin
                done_cyc   = c;
                done_seen  = done3;
                rdata_seen = rdata3;
                break;
            end
        end
        check("lat3_mem_en_cycles", 32'(en_cnt),     32'd1);
        check("lat3_done_cycle",    32'(done_cyc),   32'd5);
        check("lat3_done",          32'(done_seen),  32'h1);
        check("lat3_rdata",         32'(rdata_seen), 32'h0);
        req3 = 2'b00;
        cyc();
        check("lat3_end_busy", 32'(busy3), 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
